shift_sequencer: RTL and testbench
==================================

# shift_sequencer

Iterative shifter-operand unit for the execute stage. It accepts one shifter-operand request through a valid/ready handshake and computes the second ALU operand (val2) and the shifter carry-out over several cycles, shifting up to `STEP` positions per cycle. The sequencer replaces the single-cycle 32-bit barrel shifter on area-constrained builds. It also implements the ARM shift-by-zero encodings (LSR #32, ASR #32, RRX) and the shifter carry.

## Interface
Parameters:
- `STEP`, 4: maximum shift positions per cycle. Legal values are 1, 2, 4 and 8.

Ports:
- `clk`  in  1  clock; everything is rising-edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `start_valid`  in  1  request present.
- `start_ready`  out  1  unit can accept a request.
- `val2gen_in`  in  32  Rm value.
- `shift_operand`  in  12  instruction bits [11:0].
- `imm`  in  1  immediate form (I bit).
- `memory_instruction`  in  1  load/store offset form.
- `carry_in`  in  1  current CPSR C.
- `result_valid`  out  1  `val2` and `carry_out` are valid.
- `result_ready`  in  1  consumer takes the result.
- `val2`  out  32  operand result.
- `carry_out`  out  1  shifter carry.
- `busy`  out  1  state is not IDLE.

## Operation
- States are IDLE, SHIFT and DONE.
- **Accept.** A request is accepted when `start_valid && start_ready`; `start_ready = (state==IDLE)`. On accept the unit captures:
  - `acc <= start value`
  - `cnt <= amount`
  - `c <= carry_in`
  - the step kind.
- **Decode**, in priority order (`sh = shift_operand[6:5]`, `n5 = shift_operand[11:7]`):
  - `memory_instruction`: start value is the sign-extended `shift_operand`; amount is 0; `c = carry_in`.
  - `imm`: start value is `{24'b0, shift_operand[7:0]}`; kind is ROR; amount is `2*shift_operand[11:8]`.
  - LSL: amount is `n5`.
  - LSR: amount is `n5`, or 32 when `n5==0`.
  - ASR: amount is `n5`, or 32 when `n5==0`.
  - ROR: amount is `n5` when `n5!=0`; `n5==0` means RRX with amount 1.
- **Step.** In SHIFT, each cycle applies `k = min(cnt, STEP)` single-bit steps and then `cnt <= cnt - k`. A single-bit step does the following:
  - LSL: `c = acc[31]`, `acc = acc<<1`.
  - LSR: `c = acc[0]`, `acc = acc>>1`.
  - ASR: `c = acc[0]`, `acc = {acc[31],acc[31:1]}`.
  - ROR: `c = acc[0]`, `acc = {acc[0],acc[31:1]}`.
  - RRX: `acc = {c,acc[31:1]}`, `c = old acc[0]`.
- **Transitions.**
  - IDLE→DONE on accept with amount 0.
  - IDLE→SHIFT on accept with amount >0.
  - SHIFT→DONE when `cnt - k == 0`.
  - DONE→IDLE when `result_ready`.
- **Immediate carry.** With a non-zero rotate, `carry_out = val2[31]` after rotation; this falls out of the ROR step. With rotate 0, `carry_out = carry_in`.
- **Outputs.**
  - `val2 = acc` and `carry_out = c`, registered.
  - `result_valid = (state==DONE)`.
  - `val2` and `carry_out` are stable while `result_valid && !result_ready`.
  - `start_valid` is ignored outside IDLE.

## Timing
- Reset values: state is IDLE; `acc`, `cnt`, `c` and `val2` are 0; `carry_out` is 0; `result_valid` is 0; `start_ready` is 1; `busy` is 0.
- Reset is asynchronous and may occur mid-operation. It aborts the operation with no result, and the unit is ready in the first cycle after deassertion.
- Latency: `result_valid` rises `ceil(amount/STEP)+1` cycles after the accept edge. Examples with `STEP=4`:
  - amount 0: 1 cycle.
  - amount 5: 3 cycles.
  - amount 32: 9 cycles.
- Throughput: the next accept occurs no earlier than the cycle after DONE→IDLE, so there are no back-to-back accepts.
- Consumer stall: with `result_ready` held low, the unit stays in DONE indefinitely.
- Width rules: `cnt` is 6 bits, range 0..32; `k` is a 4-bit value.

## Structure
- A shared package holds:
  - `SH_LSL=2'b00`, `SH_LSR=2'b01`, `SH_ASR=2'b10`, `SH_ROR=2'b11`;
  - the step-kind encoding (LSL/LSR/ASR/ROR/RRX, 3 bits);
  - the state encoding (IDLE/SHIFT/DONE).
- One combinational sub-module, `shift_step`, applies `k` (0..`STEP`) single-bit steps of a given kind to `{acc, c}`. The FSM, counter and handshake stay in `shift_sequencer`.

## Test plan
- **LSL #4.** Rm=0x8000_000F, `shift_operand`=0x200, `carry_in`=0. Expect `val2`=0x0000_00F0, `carry_out`=0 (bit shifted out last is Rm[28]=0), and `result_valid` 2 cycles after accept.
- **LSR #0 (LSR #32).** Rm=0x8000_0001, `shift_operand`=0x020. Expect `val2`=0 and `carry_out`=1 after 9 cycles. Same operand with ASR (0x040): expect `val2`=0xFFFF_FFFF and `carry_out`=1.
- **RRX.** Rm=0x0000_0003, `shift_operand`=0x060, `carry_in`=1. Expect `val2`=0x8000_0001 and `carry_out`=1 after 2 cycles.
- **Immediate.** `imm`=1, `shift_operand`=0x4FF (0xFF ROR 8). Expect `val2`=0xFF00_0000 and `carry_out`=1. With `shift_operand`=0x0FF and `carry_in`=0, expect `val2`=0xFF and `carry_out`=0 after 1 cycle.
- **Memory offset.** `memory_instruction`=1, `shift_operand`=0xFFC. Expect `val2`=0xFFFF_FFFC after 1 cycle.
- **Stall and reset.** Hold `result_ready`=0 for 5 cycles: outputs stay stable and `start_ready`=0. Separately, assert `rst` during SHIFT: `busy` drops immediately and the next request completes correctly.

Source files
------------

// File: rtl/shift_sequencer_pkg.sv
// Shared encodings for the iterative shifter-operand sequencer.
package shift_sequencer_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned OP_W   = 12;
  localparam int unsigned CNT_W  = 6;
  localparam int unsigned K_W    = 4;

  localparam logic [1:0] SH_LSL = 2'b00;
  localparam logic [1:0] SH_LSR = 2'b01;
  localparam logic [1:0] SH_ASR = 2'b10;
  localparam logic [1:0] SH_ROR = 2'b11;

  typedef enum logic [2:0] {
    KIND_LSL = 3'd0,
    KIND_LSR = 3'd1,
    KIND_ASR = 3'd2,
    KIND_ROR = 3'd3,
    KIND_RRX = 3'd4
  } step_kind_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/shift_sequencer_shift_step.sv
// Applies k (0..STEP) single-bit shifter steps of one kind to {acc, c}.
module shift_step
  import shift_sequencer_pkg::*;
#(
  parameter int unsigned STEP = 4
) (
  input  logic [DATA_W-1:0] acc,
  input  logic              c,
  input  step_kind_t        kind,
  input  logic [K_W-1:0]    k,
  output logic [DATA_W-1:0] acc_next_c,
  output logic              c_next_c
);

  logic [DATA_W-1:0] a;
  logic              b;

  always_comb begin
    a = acc;
    b = c;
    for (int i = 0; i < int'(STEP); i++) begin
      if (K_W'(i) < k) begin
        unique case (kind)
          KIND_LSL: begin b = a[DATA_W-1]; a = {a[DATA_W-2:0], 1'b0}; end
          KIND_LSR: begin b = a[0]; a = {1'b0, a[DATA_W-1:1]}; end
          KIND_ASR: begin b = a[0]; a = {a[DATA_W-1], a[DATA_W-1:1]}; end
          KIND_ROR: begin b = a[0]; a = {a[0], a[DATA_W-1:1]}; end
          // carry enters at the top, old bit 0 becomes the carry
          KIND_RRX: {a, b} = {b, a};
          default:  ;
        endcase
      end
    end
    acc_next_c = a;
    c_next_c   = b;
  end

endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle shifter-operand unit: decodes an ARM operand-2 request and
// shifts up to STEP positions per cycle, handing val2/carry over a handshake.
module shift_sequencer
  import shift_sequencer_pkg::*;
#(
  parameter int unsigned STEP = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_valid,
  output logic              start_ready,
  input  logic [DATA_W-1:0] val2gen_in,
  input  logic [OP_W-1:0]   shift_operand,
  input  logic              imm,
  input  logic              memory_instruction,
  input  logic              carry_in,
  output logic              result_valid,
  input  logic              result_ready,
  output logic [DATA_W-1:0] val2,
  output logic              carry_out,
  output logic              busy
);

  state_t            state, state_next;
  logic [DATA_W-1:0] acc, acc_next;
  logic [CNT_W-1:0]  cnt, cnt_next;
  logic              c, c_next;
  step_kind_t        kind, kind_next;

  logic [DATA_W-1:0] dec_acc;
  logic [CNT_W-1:0]  dec_cnt;
  step_kind_t        dec_kind;
  logic [4:0]        n5;

  logic [K_W-1:0]    k;
  logic [CNT_W-1:0]  cnt_rem;
  logic [DATA_W-1:0] step_acc;
  logic              step_c;

  // Operand decode; zero shift amounts encode LSR/ASR #32 and RRX
  assign n5 = shift_operand[11:7];

  always_comb begin
    dec_acc  = val2gen_in;
    dec_cnt  = '0;
    dec_kind = KIND_LSL;
    if (memory_instruction) begin
      dec_acc = {{(DATA_W-OP_W){shift_operand[OP_W-1]}}, shift_operand};
    end else if (imm) begin
      dec_acc  = {24'b0, shift_operand[7:0]};
      dec_kind = KIND_ROR;
      dec_cnt  = CNT_W'({shift_operand[11:8], 1'b0});
    end else begin
      unique case (shift_operand[6:5])
        SH_LSL: begin
          dec_kind = KIND_LSL;
          dec_cnt  = CNT_W'(n5);
        end
        SH_LSR: begin
          dec_kind = KIND_LSR;
          dec_cnt  = (n5 == 5'd0) ? CNT_W'(DATA_W) : CNT_W'(n5);
        end
        SH_ASR: begin
          dec_kind = KIND_ASR;
          dec_cnt  = (n5 == 5'd0) ? CNT_W'(DATA_W) : CNT_W'(n5);
        end
        default: begin
          dec_kind = (n5 == 5'd0) ? KIND_RRX : KIND_ROR;
          dec_cnt  = (n5 == 5'd0) ? CNT_W'(1) : CNT_W'(n5);
        end
      endcase
    end
  end

  assign k       = (cnt < CNT_W'(STEP)) ? K_W'(cnt) : K_W'(STEP);
  assign cnt_rem = cnt - CNT_W'(k);

  shift_step #(.STEP(STEP)) u_step (
    .acc        (acc),
    .c          (c),
    .kind       (kind),
    .k          (k),
    .acc_next_c (step_acc),
    .c_next_c   (step_c)
  );

  // Next-state and datapath update
  always_comb begin
    state_next = state;
    acc_next   = acc;
    cnt_next   = cnt;
    c_next     = c;
    kind_next  = kind;
    unique case (state)
      ST_IDLE: begin
        if (start_valid && start_ready) begin
          acc_next   = dec_acc;
          cnt_next   = dec_cnt;
          c_next     = carry_in;
          kind_next  = dec_kind;
          state_next = (dec_cnt == '0) ? ST_DONE : ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        acc_next = step_acc;
        c_next   = step_c;
        cnt_next = cnt_rem;
        if (cnt_rem == '0) state_next = ST_DONE;
      end
      ST_DONE: begin
        if (result_ready) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      acc          <= '0;
      cnt          <= '0;
      c            <= 1'b0;
      kind         <= KIND_LSL;
      result_valid <= 1'b0;
      start_ready  <= 1'b1;
      busy         <= 1'b0;
    end else begin
      state        <= state_next;
      acc          <= acc_next;
      cnt          <= cnt_next;
      c            <= c_next;
      kind         <= kind_next;
      result_valid <= (state_next == ST_DONE);
      start_ready  <= (state_next == ST_IDLE);
      busy         <= (state_next != ST_IDLE);
    end
  end

  assign val2      = acc;
  assign carry_out = c;

endmodule

// File: tb/tb_shift_sequencer.sv
// Scoreboard bench for shift_sequencer: directed operand cases plus random ones.
module tb_shift_sequencer;

  localparam int unsigned STEP = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_valid;
  logic        start_ready;
  logic [31:0] val2gen_in;
  logic [11:0] shift_operand;
  logic        imm;
  logic        memory_instruction;
  logic        carry_in;
  logic        result_valid;
  logic        result_ready;
  logic [31:0] val2;
  logic        carry_out;
  logic        busy;

  typedef struct {
    logic [31:0] val;
    logic        c;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  shift_sequencer #(.STEP(STEP)) dut (
    .clk                (clk),
    .rst                (rst),
    .start_valid        (start_valid),
    .start_ready        (start_ready),
    .val2gen_in         (val2gen_in),
    .shift_operand      (shift_operand),
    .imm                (imm),
    .memory_instruction (memory_instruction),
    .carry_in           (carry_in),
    .result_valid       (result_valid),
    .result_ready       (result_ready),
    .val2               (val2),
    .carry_out          (carry_out),
    .busy               (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Whole-shift reference: computes the full shift at once in 64-bit arithmetic
  function automatic void model(input logic [31:0] rm, input logic [11:0] op,
                                input logic im, input logic mem, input logic cin,
                                output logic [31:0] v, output logic co, output int amt);
    logic [63:0]        w;
    logic signed [63:0] ws;
    logic [31:0]        base;
    int                 n;
    n   = int'(op[11:7]);
    v   = rm;
    co  = cin;
    amt = 0;
    if (mem) begin
      v = {{20{op[11]}}, op};
    end else if (im) begin
      base = {24'b0, op[7:0]};
      amt  = 2 * int'(op[11:8]);
      w    = {base, base} >> amt;
      v    = w[31:0];
      if (amt != 0) co = v[31];
    end else begin
      case (op[6:5])
        2'b00: begin
          amt = n;
          if (n != 0) begin
            w  = {32'b0, rm} << n;
            v  = w[31:0];
            co = w[32];
          end
        end
        2'b01: begin
          amt = (n == 0) ? 32 : n;
          w   = {rm, 32'b0} >> amt;
          v   = w[63:32];
          co  = w[31];
        end
        2'b10: begin
          amt = (n == 0) ? 32 : n;
          ws  = {rm, 32'b0};
          ws  = ws >>> amt;
          v   = ws[63:32];
          co  = ws[31];
        end
        default: begin
          if (n == 0) begin
            amt = 1;
            v   = {cin, rm[31:1]};
            co  = rm[0];
          end else begin
            amt = n;
            w   = {rm, rm} >> n;
            v   = w[31:0];
            co  = v[31];
          end
        end
      endcase
    end
  endfunction

  // Drive one request at #1 after an edge; optionally stall the consumer 5 cycles
  task automatic do_req(input logic [31:0] rm, input logic [11:0] op, input logic im,
                        input logic mem, input logic cin, input logic stall);
    exp_t        e;
    logic [31:0] v;
    logic        co;
    int          amt;
    int          lat;
    model(rm, op, im, mem, cin, v, co, amt);
    e.val = v;
    e.c   = co;
    e.lat = (amt + int'(STEP) - 1) / int'(STEP) + 1;
    sb.push_back(e);
    check("ready_before_req", 32'(start_ready), 32'd1);
    val2gen_in         = rm;
    shift_operand      = op;
    imm                = im;
    memory_instruction = mem;
    carry_in           = cin;
    start_valid        = 1'b1;
    result_ready       = !stall;
    @(posedge clk); #1;
    start_valid = 1'b0;
    lat = 1;
    while (!result_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!result_valid) begin
      check("result_timeout", 32'(result_valid), 32'd1);
      void'(sb.pop_front());
      result_ready = 1'b1;
      return;
    end
    e = sb.pop_front();
    check("val2", val2, e.val);
    check("carry_out", 32'(carry_out), 32'(e.c));
    check("latency", 32'(lat), 32'(e.lat));
    if (stall) begin
      // a competing request during DONE must be ignored
      start_valid   = 1'b1;
      val2gen_in    = ~rm;
      shift_operand = 12'h0A0;
      for (int i = 0; i < 5; i++) begin
        @(posedge clk); #1;
        check("stall_val2", val2, e.val);
        check("stall_carry", 32'(carry_out), 32'(e.c));
        check("stall_valid", 32'(result_valid), 32'd1);
        check("stall_start_ready", 32'(start_ready), 32'd0);
      end
      start_valid  = 1'b0;
      result_ready = 1'b1;
    end
    @(posedge clk); #1;
    check("valid_drop", 32'(result_valid), 32'd0);
  endtask

  initial begin
    rst                = 1'b1;
    start_valid        = 1'b0;
    val2gen_in         = '0;
    shift_operand      = '0;
    imm                = 1'b0;
    memory_instruction = 1'b0;
    carry_in           = 1'b0;
    result_ready       = 1'b1;
    #12;
    check("rst_val2", val2, 32'd0);
    check("rst_carry", 32'(carry_out), 32'd0);
    check("rst_valid", 32'(result_valid), 32'd0);
    check("rst_start_ready", 32'(start_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    do_req(32'h8000_000F, 12'h200, 1'b0, 1'b0, 1'b0, 1'b0);
    do_req(32'h8000_0001, 12'h020, 1'b0, 1'b0, 1'b0, 1'b0);
    do_req(32'h8000_0001, 12'h040, 1'b0, 1'b0, 1'b0, 1'b0);
    do_req(32'h0000_0003, 12'h060, 1'b0, 1'b0, 1'b1, 1'b0);
    do_req(32'h0000_0000, 12'h4FF, 1'b1, 1'b0, 1'b0, 1'b0);
    do_req(32'h0000_0000, 12'h0FF, 1'b1, 1'b0, 1'b0, 1'b0);
    do_req(32'h1234_5678, 12'hFFC, 1'b0, 1'b1, 1'b1, 1'b0);
    do_req(32'hA5A5_0F0F, 12'h000, 1'b0, 1'b0, 1'b1, 1'b0);
    do_req(32'h8765_4321, 12'h2E0, 1'b0, 1'b0, 1'b0, 1'b1);

    // abort an LSR #32 mid-shift
    val2gen_in    = 32'hFFFF_FFFF;
    shift_operand = 12'h020;
    start_valid   = 1'b1;
    @(posedge clk); #1;
    start_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("busy_in_shift", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_valid", 32'(result_valid), 32'd0);
    check("abort_val2", val2, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    do_req(32'h8000_0001, 12'h040, 1'b0, 1'b0, 1'b1, 1'b0);

    for (int i = 0; i < 30; i++) begin
      logic [1:0] form;
      form = 2'($urandom_range(0, 7) == 0 ? 1 : ($urandom_range(0, 7) == 0 ? 2 : 0));
      do_req($urandom, 12'($urandom), form == 2'd1, form == 2'd2, 1'($urandom),
             1'($urandom_range(0, 9) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
